// File: rtl/mem_request_sequencer.sv
// Single-outstanding load/store front-end for the cached memory module; direct ops respond memLatency+2
// cycles after accept, indirect ops 2*memLatency+3. reqReady_o is high only in IDLE, so requests are never queued.
module mem_request_sequencer #(
  parameter int ramWidth   = 8,
  parameter int addrSize   = 8,
  parameter int memLatency = 4
) (
  input  logic                clk_i,
  input  logic                clrN_i,
  input  logic                reqValid_i,
  input  logic                reqWrite_i,
  input  logic                reqIndirect_i,
  input  logic [addrSize-1:0] reqAddr_i,
  input  logic [ramWidth-1:0] reqData_i,
  output logic                reqReady_o,
  output logic                respValid_o,
  output logic [ramWidth-1:0] respData_o,
  output logic                busy_o,
  output logic                memStart_o,
  output logic [1:0]          memCntrl_o,
  output logic [addrSize-1:0] memAddr_o,
  output logic [ramWidth-1:0] memDataIn_o,
  output logic                memIsIndirect_o,
  input  logic [ramWidth-1:0] memDataOut_i
);

  localparam int CW = $clog2(memLatency + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE_PTR = 3'd1;
  localparam logic [2:0] S_WAIT_PTR  = 3'd2;
  localparam logic [2:0] S_ISSUE_OP  = 3'd3;
  localparam logic [2:0] S_WAIT_OP   = 3'd4;
  localparam logic [2:0] S_RESP      = 3'd5;

  localparam logic [1:0] C_HOLD  = 2'b00;
  localparam logic [1:0] C_READ  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;

  logic [2:0]          state_q,     state_d;
  logic [CW-1:0]       cnt_q,       cnt_d;
  logic                reqWrite_q,  reqWrite_d;
  logic [ramWidth-1:0] reqData_q,   reqData_d;
  logic                memStart_q,  memStart_d;
  logic [1:0]          memCntrl_q,  memCntrl_d;
  logic [addrSize-1:0] memAddr_q,   memAddr_d;
  logic [ramWidth-1:0] memDataIn_q, memDataIn_d;
  logic                memInd_q,    memInd_d;
  logic [ramWidth-1:0] respData_q,  respData_d;
  logic [addrSize-1:0] effAddr;

  // Pointer word becomes the effective address, resized to the address width
  generate
    if (ramWidth >= addrSize) begin : g_trunc
      assign effAddr = memDataOut_i[addrSize-1:0];
    end else begin : g_zext
      assign effAddr = {{(addrSize-ramWidth){1'b0}}, memDataOut_i};
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reqWrite_d  = reqWrite_q;
    reqData_d   = reqData_q;
    memStart_d  = 1'b0;
    memCntrl_d  = memCntrl_q;
    memAddr_d   = memAddr_q;
    memDataIn_d = memDataIn_q;
    memInd_d    = memInd_q;
    respData_d  = respData_q;
    case (state_q)
      S_IDLE: begin
        if (reqValid_i) begin
          reqWrite_d  = reqWrite_i;
          reqData_d   = reqData_i;
          memDataIn_d = reqData_i;
          memAddr_d   = reqAddr_i;
          memStart_d  = 1'b1;
          if (reqIndirect_i) begin
            state_d    = S_ISSUE_PTR;
            memCntrl_d = C_READ;
            memInd_d   = 1'b1;
          end else begin
            state_d    = S_ISSUE_OP;
            memCntrl_d = reqWrite_i ? C_WRITE : C_READ;
            memInd_d   = 1'b0;
          end
        end
      end
      S_ISSUE_PTR: begin
        cnt_d   = CW'(memLatency);
        state_d = S_WAIT_PTR;
      end
      S_WAIT_PTR: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = S_ISSUE_OP;
          memStart_d  = 1'b1;
          memAddr_d   = effAddr;
          memCntrl_d  = reqWrite_q ? C_WRITE : C_READ;
          memInd_d    = 1'b0;
          memDataIn_d = reqData_q;
        end
      end
      S_ISSUE_OP: begin
        cnt_d   = CW'(memLatency);
        state_d = S_WAIT_OP;
      end
      S_WAIT_OP: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          respData_d = reqWrite_q ? reqData_q : memDataOut_i;
          memCntrl_d = C_HOLD;
          state_d    = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!clrN_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      reqWrite_q  <= 1'b0;
      reqData_q   <= '0;
      memStart_q  <= 1'b0;
      memCntrl_q  <= C_HOLD;
      memAddr_q   <= '0;
      memDataIn_q <= '0;
      memInd_q    <= 1'b0;
      respData_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reqWrite_q  <= reqWrite_d;
      reqData_q   <= reqData_d;
      memStart_q  <= memStart_d;
      memCntrl_q  <= memCntrl_d;
      memAddr_q   <= memAddr_d;
      memDataIn_q <= memDataIn_d;
      memInd_q    <= memInd_d;
      respData_q  <= respData_d;
    end
  end

  assign reqReady_o      = (state_q == S_IDLE);
  assign busy_o          = (state_q != S_IDLE);
  assign respValid_o     = (state_q == S_RESP);
  assign respData_o      = respData_q;
  assign memStart_o      = memStart_q;
  assign memCntrl_o      = memCntrl_q;
  assign memAddr_o       = memAddr_q;
  assign memDataIn_o     = memDataIn_q;
  assign memIsIndirect_o = memInd_q;

endmodule

// File: tb/tb_mem_request_sequencer.sv
// Directed bench: memLatency=4 and memLatency=1 instances, each with a fixed-latency memory model.
module tb_mem_request_sequencer;

  logic clk = 1'b0;
  logic clrN, rv4, rv1, reqWrite, reqInd;
  logic [7:0] reqAddr, reqData;

  logic rdy4, vld4, busy4, st4, ind4, rdy1, vld1, busy1, st1, ind1;
  logic [1:0] ctl4, ctl1;
  logic [7:0] rdat4, addr4, din4, dout4, rdat1, addr1, din1, dout1;

  logic [7:0] mem4 [256];
  logic [7:0] mem1 [256];
  int mcnt4, mcnt1;
  logic [7:0] maddr4, maddr1, wa4, wd4, wa1, wd1;

  int tests_run = 0;
  int tests_failed = 0;
  int consec = 0;
  logic pst4 = 1'b0, pst1 = 1'b0;

  always #5 clk = ~clk;

  mem_request_sequencer #(.ramWidth(8), .addrSize(8), .memLatency(4)) u_dut4 (
    .clk_i(clk), .clrN_i(clrN), .reqValid_i(rv4), .reqWrite_i(reqWrite), .reqIndirect_i(reqInd),
    .reqAddr_i(reqAddr), .reqData_i(reqData), .reqReady_o(rdy4), .respValid_o(vld4),
    .respData_o(rdat4), .busy_o(busy4), .memStart_o(st4), .memCntrl_o(ctl4), .memAddr_o(addr4),
    .memDataIn_o(din4), .memIsIndirect_o(ind4), .memDataOut_i(dout4));

  mem_request_sequencer #(.ramWidth(8), .addrSize(8), .memLatency(1)) u_dut1 (
    .clk_i(clk), .clrN_i(clrN), .reqValid_i(rv1), .reqWrite_i(reqWrite), .reqIndirect_i(reqInd),
    .reqAddr_i(reqAddr), .reqData_i(reqData), .reqReady_o(rdy1), .respValid_o(vld1),
    .respData_o(rdat1), .busy_o(busy1), .memStart_o(st1), .memCntrl_o(ctl1), .memAddr_o(addr1),
    .memDataIn_o(din1), .memIsIndirect_o(ind1), .memDataOut_i(dout1));

  // Memory models: read data is valid only exactly memLatency cycles after the start pulse
  always @(posedge clk) begin
    if (!clrN) begin
      mcnt4 <= 0; mcnt1 <= 0;
    end else begin
      if (st4) begin
        mcnt4 <= 1; maddr4 <= addr4;
        if (ctl4 == 2'b10) begin wa4 <= addr4; wd4 <= din4; end
      end else if (mcnt4 != 0) mcnt4 <= mcnt4 + 1;
      if (st1) begin
        mcnt1 <= 1; maddr1 <= addr1;
        if (ctl1 == 2'b10) begin wa1 <= addr1; wd1 <= din1; end
      end else if (mcnt1 != 0) mcnt1 <= mcnt1 + 1;
    end
  end
  assign dout4 = (mcnt4 == 4) ? mem4[maddr4] : 8'hFF;
  assign dout1 = (mcnt1 == 1) ? mem1[maddr1] : 8'hFF;

  always @(negedge clk) begin
    if ((st4 && pst4) || (st1 && pst1)) consec++;
    pst4 = st4;
    pst1 = st1;
  end

  bit sel;
  logic s_rdy, s_vld, s_busy, s_st, s_ind;
  logic [1:0] s_ctl;
  logic [7:0] s_rdat, s_addr, s_din;
  assign s_rdy  = sel ? rdy1  : rdy4;
  assign s_vld  = sel ? vld1  : vld4;
  assign s_busy = sel ? busy1 : busy4;
  assign s_st   = sel ? st1   : st4;
  assign s_ind  = sel ? ind1  : ind4;
  assign s_ctl  = sel ? ctl1  : ctl4;
  assign s_rdat = sel ? rdat1 : rdat4;
  assign s_addr = sel ? addr1 : addr4;
  assign s_din  = sel ? din1  : din4;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  int cyc, nstart, resp_cyc, busy_n, stab_err;
  int st_cyc [4];
  logic [7:0] st_addr [4];
  logic [7:0] st_din [4];
  logic [1:0] st_ctl [4];
  logic st_ind [4];
  logic [7:0] resp_dat;

  // Issues one request and samples each cycle until the response pulse or the bound
  task automatic run_op(input bit s, input bit wr, input bit ind, input logic [7:0] a,
                        input logic [7:0] d, input int max_cyc);
    sel = s;
    @(negedge clk);
    reqWrite = wr; reqInd = ind; reqAddr = a; reqData = d;
    if (s) rv1 = 1'b1; else rv4 = 1'b1;
    check("ready_at_accept", {31'd0, s_rdy}, 32'd1);
    @(negedge clk);
    rv1 = 1'b0; rv4 = 1'b0;
    cyc = 1; nstart = 0; resp_cyc = 0; busy_n = 0; stab_err = 0; resp_dat = 8'h00;
    while (resp_cyc == 0 && cyc <= max_cyc) begin
      if (s_busy) busy_n++;
      if (s_st && nstart < 4) begin
        st_cyc[nstart] = cyc; st_addr[nstart] = s_addr; st_din[nstart] = s_din;
        st_ctl[nstart] = s_ctl; st_ind[nstart] = s_ind;
        nstart++;
      end else if (!s_st && !s_vld && nstart > 0) begin
        if (s_addr !== st_addr[nstart-1] || s_ctl !== st_ctl[nstart-1] ||
            s_din !== st_din[nstart-1]) stab_err++;
      end
      if (s_vld) begin
        resp_cyc = cyc; resp_dat = s_rdat;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic check_idle_after(input string tag);
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, s_rdy}, 32'd1);
    check({tag, "_busy"}, {31'd0, s_busy}, 32'd0);
    check({tag, "_vld"}, {31'd0, s_vld}, 32'd0);
    check({tag, "_ctl"}, {30'd0, s_ctl}, 32'd0);
  endtask

  int bb_ns, bb_nr;
  int bb_st [2];
  int bb_rc [2];
  logic [7:0] bb_rd [2];

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mem4[8'h12] = 8'hA5; mem4[8'h13] = 8'h3C; mem4[8'h21] = 8'h77;
    mem4[8'h04] = 8'h40; mem4[8'h40] = 8'hEE;
    mem1[8'h12] = 8'hA5; mem1[8'h04] = 8'h50;
    clrN = 1'b0; rv4 = 1'b0; rv1 = 1'b0; reqWrite = 1'b0; reqInd = 1'b0;
    reqAddr = 8'h00; reqData = 8'h00; sel = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, rdy4}, 32'd1);
    check("rst_busy", {31'd0, busy4}, 32'd0);
    check("rst_outs", {7'd0, st4, ctl4, addr4, din4, ind4, vld4}, 32'd0);
    check("rst_rdat", {24'd0, rdat4}, 32'd0);
    clrN = 1'b1;

    // Direct load
    run_op(0, 0, 0, 8'h12, 8'h00, 20);
    check("dl_nstart", nstart, 1);
    check("dl_start_cyc", st_cyc[0], 1);
    check("dl_start_sig", {22'd0, st_addr[0], st_ctl[0]}, {22'd0, 8'h12, 2'b01});
    check("dl_resp_cyc", resp_cyc, 6);
    check("dl_resp_dat", {24'd0, resp_dat}, 32'hA5);
    check("dl_busy_cycles", busy_n, 6);
    check("dl_stable", stab_err, 0);
    check_idle_after("dl_after");

    // Direct store
    run_op(0, 1, 0, 8'h30, 8'h5C, 20);
    check("ds_start_sig", {14'd0, st_addr[0], st_din[0], st_ctl[0]}, {14'd0, 8'h30, 8'h5C, 2'b10});
    check("ds_resp_cyc", resp_cyc, 6);
    check("ds_resp_dat", {24'd0, resp_dat}, 32'h5C);
    check("ds_stable", stab_err, 0);
    check("ds_mem_write", {16'd0, wa4, wd4}, {16'd0, 8'h30, 8'h5C});
    check_idle_after("ds_after");

    // Indirect load
    run_op(0, 0, 1, 8'h04, 8'h00, 20);
    check("il_nstart", nstart, 2);
    check("il_ptr_phase", {21'd0, st_addr[0], st_ctl[0], st_ind[0]}, {21'd0, 8'h04, 2'b01, 1'b1});
    check("il_op_cyc", st_cyc[1], 6);
    check("il_op_phase", {21'd0, st_addr[1], st_ctl[1], st_ind[1]}, {21'd0, 8'h40, 2'b01, 1'b0});
    check("il_resp_cyc", resp_cyc, 11);
    check("il_resp_dat", {24'd0, resp_dat}, 32'hEE);
    check("il_stable", stab_err, 0);
    check_idle_after("il_after");

    // Back-to-back loads with reqValid held high
    sel = 0; bb_ns = 0; bb_nr = 0;
    @(negedge clk);
    rv4 = 1'b1; reqWrite = 1'b0; reqInd = 1'b0; reqAddr = 8'h12;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) reqAddr = 8'h13;
      if (st4 && bb_ns < 2) begin bb_st[bb_ns] = c; bb_ns++; end
      if (vld4 && bb_nr < 2) begin bb_rc[bb_nr] = c; bb_rd[bb_nr] = rdat4; bb_nr++; end
      if (c == 7) check("bb_ready_c7", {31'd0, rdy4}, 32'd1);
      if (c == 13) rv4 = 1'b0;
    end
    check("bb_counts", {bb_ns[15:0], bb_nr[15:0]}, {16'd2, 16'd2});
    check("bb_starts", {bb_st[0][15:0], bb_st[1][15:0]}, {16'd1, 16'd8});
    check("bb_resp_cyc", {bb_rc[0][15:0], bb_rc[1][15:0]}, {16'd6, 16'd13});
    check("bb_resp_dat", {16'd0, bb_rd[0], bb_rd[1]}, {16'd0, 8'hA5, 8'h3C});
    check("bb_idle", {30'd0, rdy4, busy4}, {30'd0, 1'b1, 1'b0});

    // Reset asserted for two cycles while in WAIT_OP
    @(negedge clk);
    reqWrite = 1'b0; reqInd = 1'b0; reqAddr = 8'h12; rv4 = 1'b1;
    @(negedge clk); rv4 = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_busy", {31'd0, busy4}, 32'd1);
    clrN = 1'b0;
    @(negedge clk);
    check("mr_outs", {7'd0, st4, ctl4, addr4, din4, ind4, vld4}, 32'd0);
    check("mr_rdat_busy", {23'd0, rdat4, busy4}, 32'd0);
    check("mr_ready", {31'd0, rdy4}, 32'd1);
    @(negedge clk);
    clrN = 1'b1;
    run_op(0, 0, 0, 8'h21, 8'h00, 20);
    check("mr_resp_cyc", resp_cyc, 6);
    check("mr_resp_dat", {24'd0, resp_dat}, 32'h77);
    check_idle_after("mr_after");

    // memLatency = 1
    run_op(1, 0, 0, 8'h12, 8'h00, 10);
    check("l1_dl_resp_cyc", resp_cyc, 3);
    check("l1_dl_resp_dat", {24'd0, resp_dat}, 32'hA5);
    check_idle_after("l1_dl_after");
    run_op(1, 1, 1, 8'h04, 8'h99, 10);
    check("l1_is_starts", {st_cyc[0][15:0], st_cyc[1][15:0]}, {16'd1, 16'd3});
    check("l1_is_ptr", {21'd0, st_addr[0], st_ctl[0], st_ind[0]}, {21'd0, 8'h04, 2'b01, 1'b1});
    check("l1_is_op", {21'd0, st_addr[1], st_ctl[1], st_ind[1]}, {21'd0, 8'h50, 2'b10, 1'b0});
    check("l1_is_resp_cyc", resp_cyc, 5);
    check("l1_is_resp_dat", {24'd0, resp_dat}, 32'h99);
    check("l1_is_mem_write", {16'd0, wa1, wd1}, {16'd0, 8'h50, 8'h99});
    check_idle_after("l1_is_after");

    check("no_consecutive_start", consec, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
